// File: rtl/host_bus_pkg.sv
// host_bus_pkg
//   Shared definitions for the host memory bus: responder state encoding,
//   byte-select width and small helpers used by responders and bus masters.
package host_bus_pkg;

  localparam int BYTESEL_W = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_BUSY,
    ST_COMPL,
    ST_REFRESH
  } host_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Expands a byte select into a 16-bit lane mask.
  function automatic logic [15:0] byte_mask(input logic [BYTESEL_W-1:0] bs);
    return {{8{bs[1]}}, {8{bs[0]}}};
  endfunction

endpackage

// File: rtl/host_mem_array.sv
// host_mem_array
//   Synchronous single-port 16-bit RAM with per-byte write enables.
//   Read data is registered: rdata shows mem[addr] as sampled on the
//   previous rising edge (old data on a same-cycle write).
//   The array is deliberately not reset.
// Ports:
//   clk    - clock
//   addr   - word address
//   we     - per-byte write enable (bit0 -> [7:0], bit1 -> [15:8])
//   wdata  - write data
//   rdata  - registered read data
module host_mem_array
  import host_bus_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 15
) (
  input  logic                      clk,
  input  logic [WORD_ADDR_BITS-1:0] addr,
  input  logic [BYTESEL_W-1:0]      we,
  input  logic [15:0]               wdata,
  output logic [15:0]               rdata
);

  logic [15:0] mem [2**WORD_ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/host_mem_responder.sv
// host_mem_responder
//   Emulates a slow host-bus memory: an initialisation period after reset,
//   fixed read/write latencies, a one-cycle completion pulse and periodic
//   refresh stalls that take priority over new requests.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   h_addr         - byte address (bit 0 and bits above ADDR_BITS-1 ignored)
//   h_wr_en        - 1 = write, 0 = read
//   h_bytesel      - nonzero = request; per-byte lane select
//   h_wdata        - write data
//   h_rdata        - read data, valid with h_compl and held until next read
//   h_compl        - one-cycle completion pulse
//   h_config_done  - high once initialisation has finished
module host_mem_responder
  import host_bus_pkg::*;
#(
  parameter int ADDR_BITS      = 16,
  parameter int INIT_CYCLES    = 100,
  parameter int READ_LATENCY   = 3,
  parameter int WRITE_LATENCY  = 2,
  parameter int REFRESH_PERIOD = 390,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          h_addr,
  input  logic                 h_wr_en,
  input  logic [BYTESEL_W-1:0] h_bytesel,
  input  logic [15:0]          h_wdata,
  output logic [15:0]          h_rdata,
  output logic                 h_compl,
  output logic                 h_config_done
);

  localparam int WORD_BITS = ADDR_BITS - 1;
  localparam int CNT_W = max_int(max_int($clog2(INIT_CYCLES + 1),
                                         $clog2(REFRESH_CYCLES + 1)), 4);
  localparam int REF_W = max_int($clog2(REFRESH_PERIOD + 1), 1);

  host_state_e state, state_next;

  logic [CNT_W-1:0]     step_cnt;
  logic [REF_W-1:0]     ref_cnt;
  logic                 ref_pending;

  logic [WORD_BITS-1:0] addr_q;
  logic                 wr_q;
  logic [BYTESEL_W-1:0] bs_q;
  logic [15:0]          wdata_q;
  logic [15:0]          rdata_hold;

  logic                 capture;
  logic [CNT_W-1:0]     busy_last;
  logic [WORD_BITS-1:0] cur_addr;
  logic                 cur_wr;
  logic [BYTESEL_W-1:0] cur_bs;
  logic [15:0]          cur_wdata;
  logic [BYTESEL_W-1:0] ram_we;
  logic [15:0]          ram_rdata;
  logic [15:0]          read_word;
  logic                 rd_done;
  logic                 addr_unused;

  assign addr_unused = ^{h_addr[31:ADDR_BITS], h_addr[0]};

  // State register; step_cnt counts cycles spent in the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      step_cnt <= '0;
    end else begin
      state    <= state_next;
      step_cnt <= (state_next != state) ? '0 : step_cnt + CNT_W'(1);
    end
  end

  // BUSY is entered one cycle after capture, so it lasts latency-1 cycles.
  assign busy_last = wr_q ? CNT_W'(WRITE_LATENCY - 2) : CNT_W'(READ_LATENCY - 2);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (step_cnt == CNT_W'(INIT_CYCLES - 1)) state_next = ST_COMPL;
      end
      ST_IDLE: begin
        if (ref_pending) begin
          state_next = ST_REFRESH;
        end else if (h_bytesel != '0) begin
          capture    = 1'b1;
          state_next = (((h_wr_en ? WRITE_LATENCY : READ_LATENCY)) == 1) ? ST_COMPL : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (step_cnt == busy_last) state_next = ST_COMPL;
      end
      ST_COMPL: begin
        state_next = ST_IDLE;
      end
      ST_REFRESH: begin
        if (step_cnt == CNT_W'(REFRESH_CYCLES - 1)) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Request capture; later h_* changes are ignored until the next IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      bs_q    <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      addr_q  <= h_addr[ADDR_BITS-1:1];
      wr_q    <= h_wr_en;
      bs_q    <= h_bytesel;
      wdata_q <= h_wdata;
    end
  end

  // In IDLE the live request drives the RAM so a latency-1 access works;
  // otherwise the captured request does.
  assign cur_addr  = (state == ST_IDLE) ? h_addr[ADDR_BITS-1:1] : addr_q;
  assign cur_wr    = (state == ST_IDLE) ? h_wr_en   : wr_q;
  assign cur_bs    = (state == ST_IDLE) ? h_bytesel : bs_q;
  assign cur_wdata = (state == ST_IDLE) ? h_wdata   : wdata_q;

  // The write commits on the edge entering COMPL, so a reset while BUSY
  // forces INIT first and nothing is written.
  assign ram_we = (state != ST_INIT && state_next == ST_COMPL && cur_wr) ? cur_bs : '0;

  host_mem_array #(
    .WORD_ADDR_BITS(WORD_BITS)
  ) u_mem (
    .clk   (clk),
    .addr  (cur_addr),
    .we    (ram_we),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  assign read_word = ram_rdata & byte_mask(bs_q);
  assign rd_done   = (state == ST_COMPL) && !wr_q && (bs_q != '0);

  // Configuration flag, free-running refresh counter and single pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_config_done <= 1'b0;
      ref_cnt       <= '0;
      ref_pending   <= 1'b0;
    end else begin
      if (state == ST_INIT && state_next == ST_COMPL) h_config_done <= 1'b1;
      if (state == ST_IDLE && ref_pending) ref_pending <= 1'b0;
      if (h_config_done && REFRESH_PERIOD != 0) begin
        if (ref_cnt == REF_W'(REFRESH_PERIOD - 1)) begin
          ref_cnt     <= '0;
          ref_pending <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + REF_W'(1);
        end
      end
    end
  end

  // Read data is presented directly in the COMPL cycle and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold <= '0;
    end else if (rd_done) begin
      rdata_hold <= read_word;
    end
  end

  assign h_rdata = rd_done ? read_word : rdata_hold;
  assign h_compl = (state == ST_COMPL);

endmodule
